// File: rtl/collatz_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : collatz_sweep_ctrl_if
// Brief    : Handshake between the sweep sequencer and the collatz core.
// Revision : 1.0 - initial release
// ============================================================================
interface collatz_sweep_ctrl_if #(
    parameter int SEED_BITS = 32,
    parameter int OLEN_BITS = 16
);
    logic                 core_load;
    logic [SEED_BITS-1:0] core_seed;
    logic                 core_abort;
    logic                 core_busy;
    logic [OLEN_BITS-1:0] core_orbit_len;
    logic [OLEN_BITS-1:0] core_path_rec;

    modport master (
        output core_load, core_seed, core_abort,
        input  core_busy, core_orbit_len, core_path_rec
    );

    modport slave (
        input  core_load, core_seed, core_abort,
        output core_busy, core_orbit_len, core_path_rec
    );
endinterface
`default_nettype wire

// File: rtl/collatz_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : collatz_sweep_ctrl
// Brief    : Runs a batch of consecutive seeds through one collatz core and
//            keeps the longest-orbit champion, with a per-seed step budget.
// Revision : 1.0 - initial release
// ============================================================================
module collatz_sweep_ctrl #(
    parameter int SEED_BITS  = 32,
    parameter int OLEN_BITS  = 16,
    parameter int COUNT_BITS = 16,
    parameter int STEP_LIMIT = 1000
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  cfg_start,
    input  wire logic                  cfg_abort,
    input  wire logic [SEED_BITS-1:0]  cfg_base,
    input  wire logic [COUNT_BITS-1:0] cfg_count,
    collatz_sweep_ctrl_if.master       core,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [SEED_BITS-1:0]       best_seed,
    output logic [OLEN_BITS-1:0]       best_len,
    output logic [OLEN_BITS-1:0]       best_rec,
    output logic [COUNT_BITS-1:0]      seeds_done,
    output logic [COUNT_BITS-1:0]      timeouts
);

    localparam int                     c_STEP_BITS  = $clog2(STEP_LIMIT + 1);
    localparam logic [c_STEP_BITS-1:0] c_STEP_LIMIT = c_STEP_BITS'(STEP_LIMIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [SEED_BITS-1:0]   r_seed;
    logic [COUNT_BITS-1:0]  r_remaining;
    logic [c_STEP_BITS-1:0] r_step;
    logic [c_STEP_BITS-1:0] w_step_inc;
    logic                   r_aborted;
    logic [SEED_BITS-1:0]   r_best_seed;
    logic [OLEN_BITS-1:0]   r_best_len;
    logic [OLEN_BITS-1:0]   r_best_rec;
    logic [COUNT_BITS-1:0]  r_seeds_done;
    logic [COUNT_BITS-1:0]  r_timeouts;
    logic [COUNT_BITS-1:0]  w_seeds_done_inc;
    logic [COUNT_BITS-1:0]  w_timeouts_inc;
    logic                   w_core_load;
    logic                   w_core_abort;
    logic                   w_done;
    logic                   w_complete;
    logic                   w_timeout_hit;
    logic                   w_new_best;

    assign w_step_inc       = r_step + 1'b1;
    assign w_seeds_done_inc = (&r_seeds_done) ? r_seeds_done : r_seeds_done + 1'b1;
    assign w_timeouts_inc   = (&r_timeouts)   ? r_timeouts   : r_timeouts + 1'b1;
    // First seed of the batch always seeds the champion, even with length 0
    assign w_new_best       = (r_seeds_done == '0) || (core.core_orbit_len > r_best_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_core_load   = 1'b0;
        w_core_abort  = 1'b0;
        w_done        = 1'b0;
        w_complete    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_next_state = (cfg_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_core_load  = 1'b1;
                w_next_state = cfg_abort ? S_ABORT : S_ARM;
            end
            S_ARM: begin
                w_next_state = cfg_abort ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                // Completion beats the step budget when both land together
                if (cfg_abort) begin
                    w_next_state = S_ABORT;
                end else if (!core.core_busy) begin
                    w_complete   = 1'b1;
                    w_next_state = S_NEXT;
                end else if (w_step_inc == c_STEP_LIMIT) begin
                    w_timeout_hit = 1'b1;
                    w_core_abort  = 1'b1;
                    w_next_state  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cfg_abort) begin
                    w_next_state = S_ABORT;
                end else begin
                    w_next_state = (r_remaining == COUNT_BITS'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_ABORT: begin
                w_core_abort = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seed       <= '0;
            r_remaining  <= '0;
            r_step       <= '0;
            r_aborted    <= 1'b0;
            r_best_seed  <= '0;
            r_best_len   <= '0;
            r_best_rec   <= '0;
            r_seeds_done <= '0;
            r_timeouts   <= '0;
        end else begin
            if (w_next_state == S_ABORT && r_state != S_ABORT) begin
                r_aborted <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_seed       <= cfg_base;
                        r_remaining  <= cfg_count;
                        r_aborted    <= 1'b0;
                        r_best_seed  <= '0;
                        r_best_len   <= '0;
                        r_best_rec   <= '0;
                        r_seeds_done <= '0;
                        r_timeouts   <= '0;
                    end
                end
                S_ARM: begin
                    r_step <= '0;
                end
                S_WAIT: begin
                    r_step <= w_step_inc;
                    if (w_complete) begin
                        if (w_new_best) begin
                            r_best_seed <= r_seed;
                            r_best_len  <= core.core_orbit_len;
                            r_best_rec  <= core.core_path_rec;
                        end
                        r_seeds_done <= w_seeds_done_inc;
                    end else if (w_timeout_hit) begin
                        r_timeouts   <= w_timeouts_inc;
                        r_seeds_done <= w_seeds_done_inc;
                    end
                end
                S_NEXT: begin
                    r_seed      <= r_seed + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign core.core_load  = w_core_load;
    assign core.core_seed  = r_seed;
    assign core.core_abort = w_core_abort;

    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign aborted    = r_aborted;
    assign best_seed  = r_best_seed;
    assign best_len   = r_best_len;
    assign best_rec   = r_best_rec;
    assign seeds_done = r_seeds_done;
    assign timeouts   = r_timeouts;

endmodule
`default_nettype wire
